// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
//   arb_state_t : arbiter FSM states
//   mem_op_t    : one captured memory operation (sized to the widest
//                 address/data the arbiter is built for)
//   BE_*        : decoder byte-enable patterns for SB/SH/SW
package riscv_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   wbe;
    } mem_op_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Reads never drive byte enables onto the bus.
    function automatic logic [MEM_BE_W-1:0] be_for_op(input logic we,
                                                      input logic [MEM_BE_W-1:0] be);
        return we ? be : '0;
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Busy-cycle watchdog for the memory port arbiter.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : hold the count at zero (arbiter idle)
//   enable       : a busy cycle is in progress
//   expire       : this busy cycle is number TIMEOUT_CYCLES (0 disables)
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    // Number of busy cycles already completed; the current busy cycle is count+1.
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES > 0) && enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between instruction fetch (IF) and
// load/store (LS). One access is outstanding at a time; it is held on the
// bus until mem_ack or until the busy-cycle watchdog expires.
//   clk, reset_n                     : clock, synchronous active-low reset
//   if_valid/if_ready/if_addr        : fetch request handshake
//   if_rvalid/if_rdata/if_err        : fetch completion (pulse + held data)
//   ls_valid/ls_ready/ls_we/ls_addr/
//   ls_wdata/ls_wbe                  : load/store request handshake
//   ls_rvalid/ls_rdata/ls_err        : load/store completion
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wbe                : memory request (registered)
//   mem_ack/mem_rdata                : memory completion
// ADDR_W/DATA_W must not exceed the widths of riscv_mem_pkg::mem_op_t.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_LS_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,

    input  logic                ls_valid,
    output logic                ls_ready,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wbe,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wbe,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = (MAX_LS_STREAK < 2) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    arb_state_t        state;
    logic [SW-1:0]     streak;
    mem_op_t           op_q;
    mem_op_t           op_d;
    logic              busy;
    logic              tmo_expire;
    logic [DATA_W-1:0] resp_data;

    assign busy = (state != IDLE);

    // Accept logic. LS normally has priority; once LS has won MAX_LS_STREAK
    // times in a row against a waiting fetch, the fetch gets the next slot.
    always_comb begin
        ls_ready = reset_n && !busy && ls_valid &&
                   !(if_valid && streak == STREAK_MAX);
        if_ready = reset_n && !busy && if_valid && !ls_ready;
    end

    // Operation captured at accept. Fetches are plain reads.
    always_comb begin
        op_d = '0;
        if (ls_ready) begin
            op_d.we    = ls_we;
            op_d.addr  = MEM_ADDR_W'(ls_addr);
            op_d.wdata = MEM_DATA_W'(ls_wdata);
            op_d.wbe   = be_for_op(ls_we, MEM_BE_W'(ls_wbe));
        end else begin
            op_d.addr  = MEM_ADDR_W'(if_addr);
        end
    end

    // Stores and timeouts return zero data; only an acked read returns memory data.
    assign resp_data = (mem_ack && !op_q.we) ? mem_rdata : '0;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (!busy),
        .enable (busy),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            streak    <= '0;
            op_q      <= '0;
            mem_req   <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_ready) begin
                        op_q    <= op_d;
                        mem_req <= 1'b1;
                        state   <= BUSY_LS;
                        // Streak only grows while a fetch is actually being starved.
                        if (!if_valid)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 1'b1;
                    end else if (if_ready) begin
                        op_q    <= op_d;
                        mem_req <= 1'b1;
                        state   <= BUSY_IF;
                        streak  <= '0;
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    // An ack arriving in the expiry cycle takes precedence.
                    if (mem_ack || tmo_expire) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (state == BUSY_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= resp_data;
                            if_err    <= !mem_ack;
                        end else begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= resp_data;
                            ls_err    <= !mem_ack;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_we    = op_q.we;
    assign mem_addr  = op_q.addr[ADDR_W-1:0];
    assign mem_wdata = op_q.wdata[DATA_W-1:0];
    assign mem_wbe   = op_q.wbe[BE_W-1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference
// model and a per-cycle compare on the falling edge.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_valid = 1'b0, ls_valid = 1'b0, ls_we = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] if_addr = '0, ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0, mem_rdata = '0;
    logic [BW-1:0] ls_wbe = '0;
    logic          if_ready, if_rvalid, if_err, ls_ready, ls_rvalid, ls_err;
    logic          mem_req, mem_we;
    logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wbe;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wbe(ls_wbe),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how long, and what each port last saw.
    int            m_owner = 0;   // 0 none, 1 fetch, 2 load/store
    int            m_streak = 0;
    int            m_timer = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [BW-1:0] m_wbe = '0;
    logic          m_if_rv = 1'b0, m_if_err = 1'b0, m_ls_rv = 1'b0, m_ls_err = 1'b0;
    logic [DW-1:0] m_if_rd = '0, m_ls_rd = '0;

    function automatic int pick();
        if (!reset_n || m_owner != 0) return 0;
        if (if_valid && ls_valid) return (m_streak >= MAXS) ? 1 : 2;
        if (ls_valid) return 2;
        if (if_valid) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int            g;
        logic [DW-1:0] d;
        if (!reset_n) begin
            m_owner = 0; m_streak = 0; m_timer = 0;
            m_if_rv = 0; m_if_rd = '0; m_if_err = 0;
            m_ls_rv = 0; m_ls_rd = '0; m_ls_err = 0;
        end else begin
            m_if_rv = 0;
            m_ls_rv = 0;
            if (m_owner != 0) begin
                m_timer = m_timer + 1;
                if (mem_ack || (TMO > 0 && m_timer == TMO)) begin
                    d = (mem_ack && !m_we) ? mem_rdata : '0;
                    if (m_owner == 1) begin
                        m_if_rv = 1; m_if_rd = d; m_if_err = !mem_ack;
                    end else begin
                        m_ls_rv = 1; m_ls_rd = d; m_ls_err = !mem_ack;
                    end
                    m_owner = 0;
                end
            end else begin
                g = pick();
                if (g == 2) begin
                    m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata;
                    m_wbe = ls_we ? ls_wbe : '0;
                    m_streak = if_valid ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                end else if (g == 1) begin
                    m_we = 0; m_addr = if_addr; m_wdata = '0; m_wbe = '0;
                    m_streak = 0;
                end
                if (g != 0) begin
                    m_owner = g;
                    m_timer = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        if (chk_on) begin
            g = pick();
            check("if_ready", if_ready, g == 1);
            check("ls_ready", ls_ready, g == 2);
            check("mem_req", mem_req, m_owner != 0);
            if (m_owner != 0) begin
                check("mem_we", mem_we, m_we);
                check("mem_addr", mem_addr, m_addr);
                check("mem_wbe", mem_wbe, m_wbe);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
            check("if_rvalid", if_rvalid, m_if_rv);
            check("if_rdata", if_rdata, m_if_rd);
            check("if_err", if_err, m_if_err);
            check("ls_rvalid", ls_rvalid, m_ls_rv);
            check("ls_rdata", ls_rdata, m_ls_rd);
            check("ls_err", ls_err, m_ls_err);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int grants[10];
        int exp_g[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        int cnt;

        // Reset: ready stays low even with a pending fetch
        if_valid = 1;
        next_cycle();
        next_cycle();
        chk_on = 1;
        @(negedge clk);
        check("rst_if_ready", if_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_if_rdata", if_rdata, 0);
        next_cycle();
        reset_n = 1;
        if_valid = 0;
        next_cycle();

        // 1: lone load, ack on the third mem_req cycle
        ls_valid = 1; ls_we = 0; ls_addr = 32'h100;
        @(negedge clk);
        check("t1_ls_ready", ls_ready, 1);
        next_cycle();
        ls_valid = 0;
        @(negedge clk);
        check("t1_mem_addr", mem_addr, 32'h100);
        next_cycle();
        next_cycle();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        check("t1_ls_rvalid", ls_rvalid, 1);
        check("t1_ls_rdata", ls_rdata, 32'hDEADBEEF);
        check("t1_mem_req_off", mem_req, 0);
        next_cycle();

        // 2: SB store
        ls_valid = 1; ls_we = 1; ls_addr = 32'h104; ls_wdata = 32'hAB; ls_wbe = BE_BYTE;
        next_cycle();
        ls_valid = 0;
        @(negedge clk);
        check("t2_mem_we", mem_we, 1);
        check("t2_mem_wbe", mem_wbe, 4'b0001);
        check("t2_mem_wdata", mem_wdata, 32'hAB);
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        check("t2_ls_rvalid", ls_rvalid, 1);
        check("t2_ls_rdata", ls_rdata, 0);
        check("t2_ls_err", ls_err, 0);
        next_cycle();

        // 3: both valid, every access acked immediately
        if_valid = 1; if_addr = 32'h200;
        ls_valid = 1; ls_we = 0; ls_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            grants[i] = if_ready ? 1 : (ls_ready ? 2 : 0);
            next_cycle();
            mem_ack = 1; mem_rdata = 32'h1000 + i;
            next_cycle();
            mem_ack = 0;
        end
        if_valid = 0; ls_valid = 0;
        for (int i = 0; i < 10; i++) check($sformatf("t3_grant%0d", i), grants[i], exp_g[i]);
        @(negedge clk);
        check("t3_if_rvalid", if_rvalid, 1);
        check("t3_if_rdata", if_rdata, 32'h1009);
        next_cycle();

        // 4: fetch with no ack times out after exactly TMO mem_req cycles
        if_valid = 1; if_addr = 32'h400;
        @(negedge clk);
        check("t4_if_ready", if_ready, 1);
        next_cycle();
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!mem_req) break;
            cnt++;
            next_cycle();
        end
        check("t4_req_cycles", cnt, 64);
        check("t4_if_rvalid", if_rvalid, 1);
        check("t4_if_err", if_err, 1);
        check("t4_if_rdata", if_rdata, 0);
        check("t4_if_reaccept", if_ready, 1);
        next_cycle();
        if_valid = 0; mem_ack = 1; mem_rdata = 32'h13;
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        check("t4b_if_err", if_err, 0);
        check("t4b_if_rdata", if_rdata, 32'h13);
        next_cycle();

        // 4c: ack in the timeout cycle wins
        ls_valid = 1; ls_we = 0; ls_addr = 32'h500;
        next_cycle();
        ls_valid = 0;
        repeat (63) next_cycle();
        mem_ack = 1; mem_rdata = 32'h5A5A;
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        check("t4c_ls_rvalid", ls_rvalid, 1);
        check("t4c_ls_err", ls_err, 0);
        check("t4c_ls_rdata", ls_rdata, 32'h5A5A);
        next_cycle();

        // 5: reset during a load abandons it; pending fetch goes after release
        ls_valid = 1; ls_we = 0; ls_addr = 32'h600;
        next_cycle();
        ls_valid = 0; if_valid = 1; if_addr = 32'h700;
        next_cycle();
        reset_n = 0;
        next_cycle();
        @(negedge clk);
        check("t5_mem_req", mem_req, 0);
        check("t5_ls_rvalid", ls_rvalid, 0);
        check("t5_ls_rdata", ls_rdata, 0);
        check("t5_if_ready_rst", if_ready, 0);
        next_cycle();
        reset_n = 1;
        @(negedge clk);
        check("t5_if_ready", if_ready, 1);
        next_cycle();
        if_valid = 0; mem_ack = 1; mem_rdata = 32'h77;
        @(negedge clk);
        check("t5_mem_addr", mem_addr, 32'h700);
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        check("t5_if_rvalid", if_rvalid, 1);
        next_cycle();

        // 6: ack alongside a new valid; then stray acks while idle
        ls_valid = 1; ls_we = 1; ls_addr = 32'h800; ls_wdata = 32'h1234_5678; ls_wbe = BE_WORD;
        next_cycle();
        ls_valid = 0; mem_ack = 1; if_valid = 1; if_addr = 32'h900;
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        check("t6_ls_rvalid", ls_rvalid, 1);
        check("t6_if_ready", if_ready, 1);
        next_cycle();
        if_valid = 0; mem_ack = 1; mem_rdata = 32'h99;
        next_cycle();
        mem_rdata = 32'hBAD;
        next_cycle();
        next_cycle();
        mem_ack = 0;
        @(negedge clk);
        check("t6_stray_if_rvalid", if_rvalid, 0);
        check("t6_stray_mem_req", mem_req, 0);
        check("t6_if_rdata_held", if_rdata, 32'h99);
        next_cycle();
        next_cycle();

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
